// File: rtl/fprint_store.sv
// Per-task fingerprint store: per-core circular queues of CRC fingerprints with
// check-in tracking, presenting the tail pair of the task under comparison.
module fprint_store #(
    parameter int CRC_WIDTH     = 32,
    parameter int CRC_KEY_WIDTH = 4,
    parameter int CRC_KEY_SIZE  = 16,
    parameter int DEPTH_LOG2    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fp_write0,
    input  logic                     fp_write1,
    input  logic [CRC_KEY_WIDTH-1:0] fp_task0,
    input  logic [CRC_KEY_WIDTH-1:0] fp_task1,
    input  logic [CRC_WIDTH-1:0]     fp_data0,
    input  logic [CRC_WIDTH-1:0]     fp_data1,
    input  logic                     task_done0,
    input  logic                     task_done1,
    input  logic [CRC_KEY_WIDTH-1:0] comp_task,
    input  logic                     comp_increment_tail_pointer,
    input  logic                     comp_reset_fprint_ready,
    input  logic                     comp_task_verified,
    output logic                     reset_fprint_ack,
    output logic                     fprint_reg_ack,
    output logic [CRC_KEY_SIZE-1:0]  fprints_ready,
    output logic [CRC_KEY_SIZE-1:0]  checkin,
    output logic [CRC_WIDTH-1:0]     fprint0,
    output logic [CRC_WIDTH-1:0]     fprint1,
    output logic                     head0_matches_head1,
    output logic                     tail0_matches_head0,
    output logic                     tail1_matches_head1,
    output logic                     overflow_error
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    typedef logic [PW-1:0] ptr_t;

    logic [CRC_WIDTH-1:0] mem0 [CRC_KEY_SIZE][DEPTH];
    logic [CRC_WIDTH-1:0] mem1 [CRC_KEY_SIZE][DEPTH];
    ptr_t head0 [CRC_KEY_SIZE], tail0 [CRC_KEY_SIZE];
    ptr_t head1 [CRC_KEY_SIZE], tail1 [CRC_KEY_SIZE];
    ptr_t head0_n [CRC_KEY_SIZE], tail0_n [CRC_KEY_SIZE];
    ptr_t head1_n [CRC_KEY_SIZE], tail1_n [CRC_KEY_SIZE];
    logic [CRC_KEY_SIZE-1:0] done0, done1, ready_q;
    logic [CRC_KEY_SIZE-1:0] done0_n, done1_n, ready_n;

    logic fire_rst, fire_ver, kill0, kill1, full0, full1;
    logic wr0_ok, wr1_ok, ovf, inc0, inc1;

    assign fire_rst = comp_reset_fprint_ready & ~reset_fprint_ack;
    assign fire_ver = comp_task_verified & ~fprint_reg_ack;
    // A retire of the same task wins over any write or check-in this cycle
    assign kill0    = fire_ver & (fp_task0 == comp_task);
    assign kill1    = fire_ver & (fp_task1 == comp_task);
    assign full0    = (head0[fp_task0] - tail0[fp_task0]) == PW'(DEPTH);
    assign full1    = (head1[fp_task1] - tail1[fp_task1]) == PW'(DEPTH);
    assign wr0_ok   = fp_write0 & ~full0 & ~kill0;
    assign wr1_ok   = fp_write1 & ~full1 & ~kill1;
    assign ovf      = (fp_write0 & full0 & ~kill0) | (fp_write1 & full1 & ~kill1);
    assign inc0     = comp_increment_tail_pointer & ~fire_ver &
                      (head0[comp_task] != tail0[comp_task]);
    assign inc1     = comp_increment_tail_pointer & ~fire_ver &
                      (head1[comp_task] != tail1[comp_task]);

    always_comb begin
        head0_n = head0;
        tail0_n = tail0;
        head1_n = head1;
        tail1_n = tail1;
        done0_n = done0;
        done1_n = done1;
        ready_n = ready_q;
        if (wr0_ok) head0_n[fp_task0] = head0[fp_task0] + PW'(1);
        if (wr1_ok) head1_n[fp_task1] = head1[fp_task1] + PW'(1);
        if (inc0)   tail0_n[comp_task] = tail0[comp_task] + PW'(1);
        if (inc1)   tail1_n[comp_task] = tail1[comp_task] + PW'(1);
        if (task_done0 && !kill0) done0_n[fp_task0] = 1'b1;
        if (task_done1 && !kill1) done1_n[fp_task1] = 1'b1;
        if (fire_rst) ready_n[comp_task] = 1'b0;
        if (fire_ver) begin
            head0_n[comp_task] = '0;
            tail0_n[comp_task] = '0;
            head1_n[comp_task] = '0;
            tail1_n[comp_task] = '0;
            done0_n[comp_task] = 1'b0;
            done1_n[comp_task] = 1'b0;
            ready_n[comp_task] = 1'b0;
        end
        // Ready is judged on the post-write pointers of the written task
        for (int t = 0; t < CRC_KEY_SIZE; t++) begin
            if (((wr0_ok && fp_task0 == CRC_KEY_WIDTH'(t)) ||
                 (wr1_ok && fp_task1 == CRC_KEY_WIDTH'(t))) &&
                (head0_n[t] != tail0_n[t]) && (head1_n[t] != tail1_n[t]))
                ready_n[t] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < CRC_KEY_SIZE; t++) begin
                head0[t] <= '0;
                tail0[t] <= '0;
                head1[t] <= '0;
                tail1[t] <= '0;
            end
            done0            <= '0;
            done1            <= '0;
            ready_q          <= '0;
            overflow_error   <= 1'b0;
            reset_fprint_ack <= 1'b0;
            fprint_reg_ack   <= 1'b0;
        end else begin
            head0            <= head0_n;
            tail0            <= tail0_n;
            head1            <= head1_n;
            tail1            <= tail1_n;
            done0            <= done0_n;
            done1            <= done1_n;
            ready_q          <= ready_n;
            overflow_error   <= overflow_error | ovf;
            reset_fprint_ack <= fire_rst;
            fprint_reg_ack   <= fire_ver;
        end
    end

    // Fingerprint storage is not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (wr0_ok) mem0[fp_task0][head0[fp_task0][DEPTH_LOG2-1:0]] <= fp_data0;
        if (wr1_ok) mem1[fp_task1][head1[fp_task1][DEPTH_LOG2-1:0]] <= fp_data1;
    end

    assign checkin             = done0 & done1;
    assign fprints_ready       = ready_q;
    assign fprint0             = mem0[comp_task][tail0[comp_task][DEPTH_LOG2-1:0]];
    assign fprint1             = mem1[comp_task][tail1[comp_task][DEPTH_LOG2-1:0]];
    assign head0_matches_head1 = head0[comp_task] == head1[comp_task];
    assign tail0_matches_head0 = tail0[comp_task] == head0[comp_task];
    assign tail1_matches_head1 = tail1[comp_task] == head1[comp_task];
endmodule

// File: tb/tb_fprint_store.sv
// Scoreboard bench for fprint_store: expected fingerprints are queued per core
// on write and popped as the comparator advances the tails.
module tb_fprint_store;
    logic        clk = 1'b0;
    logic        reset;
    logic        fp_write0, fp_write1, task_done0, task_done1;
    logic [3:0]  fp_task0, fp_task1, comp_task;
    logic [31:0] fp_data0, fp_data1;
    logic        comp_increment_tail_pointer, comp_reset_fprint_ready, comp_task_verified;
    logic        reset_fprint_ack, fprint_reg_ack, overflow_error;
    logic [15:0] fprints_ready, checkin;
    logic [31:0] fprint0, fprint1;
    logic        head0_matches_head1, tail0_matches_head0, tail1_matches_head1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic [31:0] exp0, exp1;

    always #5 clk = ~clk;

    fprint_store dut (
        .clk(clk), .reset(reset),
        .fp_write0(fp_write0), .fp_write1(fp_write1),
        .fp_task0(fp_task0), .fp_task1(fp_task1),
        .fp_data0(fp_data0), .fp_data1(fp_data1),
        .task_done0(task_done0), .task_done1(task_done1),
        .comp_task(comp_task),
        .comp_increment_tail_pointer(comp_increment_tail_pointer),
        .comp_reset_fprint_ready(comp_reset_fprint_ready),
        .comp_task_verified(comp_task_verified),
        .reset_fprint_ack(reset_fprint_ack), .fprint_reg_ack(fprint_reg_ack),
        .fprints_ready(fprints_ready), .checkin(checkin),
        .fprint0(fprint0), .fprint1(fprint1),
        .head0_matches_head1(head0_matches_head1),
        .tail0_matches_head0(tail0_matches_head0),
        .tail1_matches_head1(tail1_matches_head1),
        .overflow_error(overflow_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fp_write0 = 0; fp_write1 = 0; task_done0 = 0; task_done1 = 0;
        comp_increment_tail_pointer = 0;
    endtask

    task automatic test_reset();
        idle();
        fp_task0 = 0; fp_task1 = 0; fp_data0 = 0; fp_data1 = 0;
        comp_task = 0; comp_reset_fprint_ready = 0; comp_task_verified = 0;
        reset = 1;
        #3;
        n_vec++;
        if ({reset_fprint_ack, fprint_reg_ack, overflow_error} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {reset_fprint_ack, fprint_reg_ack, overflow_error});
        end
        n_vec++;
        if ({fprints_ready, checkin} !== 32'h0) begin
            n_err++; $display("FAIL reset_vectors: got %h want 0", {fprints_ready, checkin});
        end
        n_vec++;
        if ({head0_matches_head1, tail0_matches_head0, tail1_matches_head1} !== 3'b111) begin
            n_err++; $display("FAIL reset_match: got %b want 111", {head0_matches_head1, tail0_matches_head0, tail1_matches_head1});
        end
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic test_write_pair();
        comp_task = 3;
        fp_write0 = 1; fp_write1 = 1; fp_task0 = 3; fp_task1 = 3;
        fp_data0 = 32'hDEADBEEF; fp_data1 = 32'hDEADBEEF;
        sb0.push_back(32'hDEADBEEF); sb1.push_back(32'hDEADBEEF);
        tick(); idle();
        n_vec++;
        if (fprints_ready !== 16'h0008) begin
            n_err++; $display("FAIL pair_ready: got %h want 0008", fprints_ready);
        end
        n_vec++;
        if (fprint0 !== sb0[0] || fprint1 !== sb1[0]) begin
            n_err++; $display("FAIL pair_data: got %h/%h want %h/%h", fprint0, fprint1, sb0[0], sb1[0]);
        end
        n_vec++;
        if (head0_matches_head1 !== 1'b1 || tail0_matches_head0 !== 1'b0) begin
            n_err++; $display("FAIL pair_match: got h01=%b t0h0=%b want 1 0", head0_matches_head1, tail0_matches_head0);
        end
    endtask

    task automatic test_tail_increment();
        fp_write0 = 1; fp_write1 = 1; fp_data0 = 32'h12345678; fp_data1 = 32'hCAFEF00D;
        sb0.push_back(32'h12345678); sb1.push_back(32'hCAFEF00D);
        tick(); idle();
        for (int i = 0; i < 2; i++) begin
            exp0 = sb0.pop_front(); exp1 = sb1.pop_front();
            n_vec++;
            if (fprint0 !== exp0 || fprint1 !== exp1) begin
                n_err++; $display("FAIL inc_data%0d: got %h/%h want %h/%h", i, fprint0, fprint1, exp0, exp1);
            end
            n_vec++;
            if (tail0_matches_head0 !== 1'b0 || tail1_matches_head1 !== 1'b0) begin
                n_err++; $display("FAIL inc_nonempty%0d: got %b%b want 00", i, tail0_matches_head0, tail1_matches_head1);
            end
            comp_increment_tail_pointer = 1;
            tick(); idle();
        end
        n_vec++;
        if (tail0_matches_head0 !== 1'b1 || tail1_matches_head1 !== 1'b1) begin
            n_err++; $display("FAIL inc_empty: got %b%b want 11", tail0_matches_head0, tail1_matches_head1);
        end
        comp_increment_tail_pointer = 1;
        tick(); idle();
        n_vec++;
        if ({head0_matches_head1, tail0_matches_head0, tail1_matches_head1} !== 3'b111) begin
            n_err++; $display("FAIL inc_extra: got %b want 111", {head0_matches_head1, tail0_matches_head0, tail1_matches_head1});
        end
        n_vec++;
        if (fprints_ready !== 16'h0008) begin
            n_err++; $display("FAIL inc_ready_kept: got %h want 0008", fprints_ready);
        end
    endtask

    task automatic test_ready_reset();
        comp_task = 3;
        comp_reset_fprint_ready = 1;
        n_vec++;
        if (reset_fprint_ack !== 1'b0) begin
            n_err++; $display("FAIL rr_ack0: got %b want 0", reset_fprint_ack);
        end
        tick();
        n_vec++;
        if (reset_fprint_ack !== 1'b1 || fprints_ready !== 16'h0000) begin
            n_err++; $display("FAIL rr_ack1: got ack=%b ready=%h want 1 0000", reset_fprint_ack, fprints_ready);
        end
        tick();
        n_vec++;
        if (reset_fprint_ack !== 1'b0) begin
            n_err++; $display("FAIL rr_ack2: got %b want 0", reset_fprint_ack);
        end
        comp_reset_fprint_ready = 0;
        tick();
        n_vec++;
        if (reset_fprint_ack !== 1'b0) begin
            n_err++; $display("FAIL rr_ack3: got %b want 0", reset_fprint_ack);
        end
    endtask

    task automatic test_overflow();
        comp_task = 7;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (overflow_error !== 1'b0) begin
                n_err++; $display("FAIL ovf_early%0d: got %b want 0", i, overflow_error);
            end
            fp_write0 = 1; fp_task0 = 7; fp_data0 = 32'h7000_0000 + i;
            if (i < 4) sb0.push_back(32'h7000_0000 + i);
            tick(); idle();
        end
        n_vec++;
        if (overflow_error !== 1'b1) begin
            n_err++; $display("FAIL ovf_set: got %b want 1", overflow_error);
        end
        for (int i = 0; i < 4; i++) begin
            exp0 = sb0.pop_front();
            n_vec++;
            if (fprint0 !== exp0) begin
                n_err++; $display("FAIL ovf_data%0d: got %h want %h", i, fprint0, exp0);
            end
            comp_increment_tail_pointer = 1;
            tick(); idle();
        end
        n_vec++;
        if (tail0_matches_head0 !== 1'b1 || head0_matches_head1 !== 1'b0) begin
            n_err++; $display("FAIL ovf_wrap0: got t0h0=%b h01=%b want 1 0", tail0_matches_head0, head0_matches_head1);
        end
        for (int i = 0; i < 4; i++) begin
            fp_write1 = 1; fp_task1 = 7; fp_data1 = 32'h7100_0000 + i;
            sb1.push_back(32'h7100_0000 + i);
            tick(); idle();
        end
        n_vec++;
        if (head0_matches_head1 !== 1'b1 || tail1_matches_head1 !== 1'b0 || fprint1 !== sb1[0]) begin
            n_err++; $display("FAIL ovf_wrap1: got h01=%b t1h1=%b fp1=%h want 1 0 %h", head0_matches_head1, tail1_matches_head1, fprint1, sb1[0]);
        end
        n_vec++;
        if (fprints_ready !== 16'h0000 || overflow_error !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky: got ready=%h ovf=%b want 0000 1", fprints_ready, overflow_error);
        end
        sb1.delete();
    endtask

    task automatic test_back_to_back();
        comp_task = 5;
        fp_write0 = 1; fp_write1 = 1; fp_task0 = 5; fp_task1 = 5;
        fp_data0 = 32'hA5A5_0001; fp_data1 = 32'h5A5A_0001;
        sb0.push_back(fp_data0); sb1.push_back(fp_data1);
        tick(); idle();
        n_vec++;
        if (fprints_ready !== 16'h0020) begin
            n_err++; $display("FAIL b2b_ready: got %h want 0020", fprints_ready);
        end
        fp_write0 = 1; fp_data0 = 32'hA5A5_0002; comp_increment_tail_pointer = 1;
        sb0.push_back(fp_data0);
        void'(sb0.pop_front()); void'(sb1.pop_front());
        tick(); idle();
        n_vec++;
        if (fprint0 !== sb0[0] || tail0_matches_head0 !== 1'b0 || tail1_matches_head1 !== 1'b1) begin
            n_err++; $display("FAIL b2b_wr_inc: got fp0=%h t0h0=%b t1h1=%b want %h 0 1", fprint0, tail0_matches_head0, tail1_matches_head1, sb0[0]);
        end
        sb0.delete();
    endtask

    task automatic test_retire();
        fp_write0 = 1; fp_write1 = 1; fp_task0 = 2; fp_task1 = 2;
        fp_data0 = 32'h2222_0000; fp_data1 = 32'h2222_1111; task_done0 = 1;
        tick(); idle();
        n_vec++;
        if (checkin !== 16'h0000 || fprints_ready !== 16'h0024) begin
            n_err++; $display("FAIL ret_half: got checkin=%h ready=%h want 0000 0024", checkin, fprints_ready);
        end
        task_done1 = 1; fp_task1 = 2;
        tick(); idle();
        n_vec++;
        if (checkin !== 16'h0004) begin
            n_err++; $display("FAIL ret_checkin: got %h want 0004", checkin);
        end
        comp_task = 2; comp_task_verified = 1;
        fp_write1 = 1; fp_task1 = 2; fp_data1 = 32'hBAD0_BAD0;
        tick(); idle();
        n_vec++;
        if (fprint_reg_ack !== 1'b1 || checkin !== 16'h0000 || fprints_ready !== 16'h0020) begin
            n_err++; $display("FAIL ret_ack: got ack=%b checkin=%h ready=%h want 1 0000 0020", fprint_reg_ack, checkin, fprints_ready);
        end
        n_vec++;
        if ({head0_matches_head1, tail0_matches_head0, tail1_matches_head1} !== 3'b111) begin
            n_err++; $display("FAIL ret_ptrs: got %b want 111", {head0_matches_head1, tail0_matches_head0, tail1_matches_head1});
        end
        comp_task_verified = 0;
        tick();
        n_vec++;
        if (fprint_reg_ack !== 1'b0 || tail1_matches_head1 !== 1'b1) begin
            n_err++; $display("FAIL ret_after: got ack=%b t1h1=%b want 0 1", fprint_reg_ack, tail1_matches_head1);
        end
    endtask

    task automatic test_reset_mid_retire();
        fp_write0 = 1; fp_write1 = 1; fp_task0 = 9; fp_task1 = 9;
        fp_data0 = 32'h9999_0000; fp_data1 = 32'h9999_1111;
        task_done0 = 1; task_done1 = 1;
        tick(); idle();
        n_vec++;
        if (fprints_ready !== 16'h0220 || checkin !== 16'h0200) begin
            n_err++; $display("FAIL mid_pre: got ready=%h checkin=%h want 0220 0200", fprints_ready, checkin);
        end
        comp_task = 3; comp_task_verified = 1;
        tick();
        n_vec++;
        if (fprint_reg_ack !== 1'b1) begin
            n_err++; $display("FAIL mid_ack: got %b want 1", fprint_reg_ack);
        end
        reset = 1;
        #1;
        n_vec++;
        if ({fprint_reg_ack, reset_fprint_ack, overflow_error, fprints_ready, checkin} !== 35'h0) begin
            n_err++; $display("FAIL mid_async: got ack=%b rack=%b ovf=%b ready=%h checkin=%h want all 0", fprint_reg_ack, reset_fprint_ack, overflow_error, fprints_ready, checkin);
        end
        comp_task_verified = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (fprint_reg_ack !== 1'b0) begin
                n_err++; $display("FAIL mid_noack%0d: got %b want 0", i, fprint_reg_ack);
            end
        end
        comp_task_verified = 1;
        tick();
        comp_task_verified = 0;
        n_vec++;
        if (fprint_reg_ack !== 1'b1) begin
            n_err++; $display("FAIL mid_newreq: got %b want 1", fprint_reg_ack);
        end
    endtask

    initial begin
        test_reset();
        test_write_pair();
        test_tail_increment();
        test_ready_reset();
        test_overflow();
        test_back_to_back();
        test_retire();
        test_reset_mid_retire();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
